button_event_unit: RTL and testbench

Conditions the five raw front-panel buttons (scroll_up, scroll_down, select, back, pause_play) before the controller's PicoBlaze input mux reads them. Each button is synchronised, debounced and edge-detected. Presses are latched into a sticky event register, which the PicoBlaze program polls and clears by reading it. scroll_up and scroll_down also auto-repeat while held, so menu scrolling needs no software timing.

---
 rtl/button_event_if.sv | 19 +
 rtl/button_event_unit.sv | 188 ++++++++++++++++++
 tb/tb_button_event_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/button_event_if.sv
// Front-panel button / PicoBlaze port bundle between the controller and button_event_unit.
interface button_event_if;
  logic [4:0] btn_raw;
  logic [7:0] port_id;
  logic       read_strobe;
  logic [7:0] event_flags;
  logic [4:0] btn_level;
  logic       event_pending;

  modport master (
    output btn_raw, port_id, read_strobe,
    input  event_flags, btn_level, event_pending
  );

  modport slave (
    input  btn_raw, port_id, read_strobe,
    output event_flags, btn_level, event_pending
  );
endinterface

// File: rtl/button_event_unit.sv
// Synchronises, debounces and edge-detects five front-panel buttons into a sticky,
// read-to-clear event register; scroll_up/scroll_down auto-repeat while held.
module button_event_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_RATE     = 10000000,
  parameter logic [7:0]  EVENT_PORT      = 8'h0C
) (
  input  logic        clk,
  input  logic        pb_reset,
  button_event_if.slave bus
);

  localparam int unsigned      DB_W       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned      RC_W       = 26;
  localparam logic [RC_W-1:0]  DELAY_LAST = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0]  RATE_LAST  = RC_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  logic [4:0]      r_sync1;
  logic [4:0]      r_sync2;
  logic [4:0]      r_level;
  logic [DB_W-1:0] r_db_cnt [5];
  logic [4:0]      w_db_mismatch;
  logic [4:0]      w_db_done;
  logic [4:0]      w_rise;
  logic [4:0]      w_fall;

  rpt_state_t      r_rpt_state     [2];
  rpt_state_t      w_rpt_state_nxt [2];
  logic [RC_W-1:0] r_rpt_cnt       [2];
  logic [RC_W-1:0] w_rpt_cnt_nxt   [2];
  logic [1:0]      w_rpt_evt;

  logic [5:0]      r_flags;
  logic [5:0]      r_snap;
  logic            r_pending;
  logic [5:0]      w_flags_nxt;
  logic [5:0]      w_clr_mask;
  logic [4:0]      w_evt;
  logic            w_clear;
  logic            w_ovf;

  // Two-flop synchroniser on the raw buttons
  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      r_sync1 <= 5'd0;
      r_sync2 <= 5'd0;
    end else begin
      r_sync1 <= bus.btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_db_mismatch = 5'd0;
    w_db_done     = 5'd0;
    for (int i = 0; i < 5; i++) begin
      w_db_mismatch[i] = r_sync2[i] ^ r_level[i];
      w_db_done[i]     = w_db_mismatch[i] & (r_db_cnt[i] == DB_LAST);
    end
  end

  // Edge detect is taken from the toggle condition so the event lands with the level change
  assign w_rise = w_db_done & ~r_level;
  assign w_fall = w_db_done & r_level;

  // Debounce counters and accepted levels
  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      r_level <= 5'd0;
      for (int i = 0; i < 5; i++) begin
        r_db_cnt[i] <= {DB_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (!w_db_mismatch[i]) begin
          r_db_cnt[i] <= {DB_W{1'b0}};
        end else if (w_db_done[i]) begin
          r_db_cnt[i] <= {DB_W{1'b0}};
          r_level[i]  <= ~r_level[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Auto-repeat FSM state and counter registers (scroll_up, scroll_down)
  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      for (int i = 0; i < 2; i++) begin
        r_rpt_state[i] <= RPT_IDLE;
        r_rpt_cnt[i]   <= {RC_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_rpt_state[i] <= w_rpt_state_nxt[i];
        r_rpt_cnt[i]   <= w_rpt_cnt_nxt[i];
      end
    end
  end

  // A release always wins over a timer expiry on the same edge
  always_comb begin
    w_rpt_evt = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_rpt_state_nxt[i] = r_rpt_state[i];
      w_rpt_cnt_nxt[i]   = r_rpt_cnt[i];
      case (r_rpt_state[i])
        RPT_IDLE: begin
          w_rpt_cnt_nxt[i] = {RC_W{1'b0}};
          if (w_rise[i]) begin
            w_rpt_state_nxt[i] = RPT_DELAY;
          end else begin
            w_rpt_state_nxt[i] = RPT_IDLE;
          end
        end
        RPT_DELAY: begin
          if (w_fall[i]) begin
            w_rpt_state_nxt[i] = RPT_IDLE;
            w_rpt_cnt_nxt[i]   = {RC_W{1'b0}};
          end else if (r_rpt_cnt[i] == DELAY_LAST) begin
            w_rpt_state_nxt[i] = RPT_REPEAT;
            w_rpt_cnt_nxt[i]   = {RC_W{1'b0}};
            w_rpt_evt[i]       = 1'b1;
          end else begin
            w_rpt_cnt_nxt[i]   = r_rpt_cnt[i] + RC_W'(1);
          end
        end
        RPT_REPEAT: begin
          if (w_fall[i]) begin
            w_rpt_state_nxt[i] = RPT_IDLE;
            w_rpt_cnt_nxt[i]   = {RC_W{1'b0}};
          end else if (r_rpt_cnt[i] == RATE_LAST) begin
            w_rpt_cnt_nxt[i]   = {RC_W{1'b0}};
            w_rpt_evt[i]       = 1'b1;
          end else begin
            w_rpt_cnt_nxt[i]   = r_rpt_cnt[i] + RC_W'(1);
          end
        end
        default: begin
          w_rpt_state_nxt[i] = RPT_IDLE;
          w_rpt_cnt_nxt[i]   = {RC_W{1'b0}};
        end
      endcase
    end
  end

  // The clear only removes bits captured by the snapshot; fresh events always win
  always_comb begin
    w_flags_nxt = 6'd0;
    w_evt       = w_rise | {3'b000, w_rpt_evt};
    w_clear     = bus.read_strobe & (bus.port_id == EVENT_PORT);
    if (w_clear) begin
      w_clr_mask = r_snap;
    end else begin
      w_clr_mask = 6'd0;
    end
    w_ovf            = |(w_evt & r_flags[4:0] & ~w_clr_mask[4:0]);
    w_flags_nxt[4:0] = (r_flags[4:0] & ~w_clr_mask[4:0]) | w_evt;
    w_flags_nxt[5]   = (r_flags[5] & ~w_clr_mask[5]) | w_ovf;
  end

  // Event register, the controller-side snapshot and the pending flag
  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      r_flags   <= 6'd0;
      r_snap    <= 6'd0;
      r_pending <= 1'b0;
    end else begin
      r_flags   <= w_flags_nxt;
      r_snap    <= r_flags;
      r_pending <= |w_flags_nxt;
    end
  end

  assign bus.event_flags   = {2'b00, r_flags};
  assign bus.btn_level     = r_level;
  assign bus.event_pending = r_pending;

endmodule

// File: tb/tb_button_event_unit.sv
// Scoreboard bench for button_event_unit: expectations are queued with the cycle they are due.
module tb_button_event_unit;
  localparam int unsigned DB   = 4;
  localparam int unsigned RD   = 20;
  localparam int unsigned RR   = 8;
  localparam logic [7:0]  PORT = 8'h0C;

  typedef struct {
    int         cyc;
    string      tag;
    logic [7:0] flags;
    logic [4:0] level;
  } exp_t;

  logic   clk;
  logic   pb_reset;
  int     cyc;
  int     n_checks;
  int     n_errors;
  exp_t   exp_q[$];

  button_event_if u_if ();

  button_event_unit #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .EVENT_PORT     (PORT)
  ) u_dut (
    .clk     (clk),
    .pb_reset(pb_reset),
    .bus     (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input int c, input string tag, input logic [7:0] f, input logic [4:0] l);
    exp_t e;
    e.cyc   = c;
    e.tag   = tag;
    e.flags = f;
    e.level = l;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  // Port held for two cycles, strobe on the second; the clearing edge is cycle s
  task automatic read_at(input int s, input logic [7:0] port);
    wait_until(s - 2);
    u_if.port_id = port;
    tick(1);
    u_if.read_strobe = 1'b1;
    tick(1);
    u_if.read_strobe = 1'b0;
    u_if.port_id     = 8'h00;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_flags"}, 32'(u_if.event_flags), 32'h0);
    check_eq({tag, "_level"}, 32'(u_if.btn_level), 32'h0);
    check_eq({tag, "_pend"}, 32'(u_if.event_pending), 32'h0);
  endtask

  // Compare every expectation due this cycle; anything overdue is reported
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc < cyc) begin
        check_eq({exp_q[i].tag, "_late"}, 32'(cyc), 32'(exp_q[i].cyc));
        exp_q.delete(i);
      end else if (exp_q[i].cyc == cyc) begin
        check_eq({exp_q[i].tag, "_flags"}, 32'(u_if.event_flags), 32'(exp_q[i].flags));
        check_eq({exp_q[i].tag, "_level"}, 32'(u_if.btn_level), 32'(exp_q[i].level));
        check_eq({exp_q[i].tag, "_pend"}, 32'(u_if.event_pending), 32'(|exp_q[i].flags[5:0]));
        exp_q.delete(i);
      end
    end
  end

  initial begin
    #60000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int a;
    int q;
    int r;
    n_checks         = 0;
    n_errors         = 0;
    pb_reset         = 1'b1;
    u_if.btn_raw     = 5'd0;
    u_if.port_id     = 8'h00;
    u_if.read_strobe = 1'b0;
    tick(3);
    check_all_zero("reset");
    pb_reset = 1'b0;

    // Mid-run asynchronous reset after a pause_play press
    n = cyc;
    u_if.btn_raw = 5'b10000;
    push_exp(n + 6, "pp_press", 8'h10, 5'h10);
    tick(8);
    #2;
    pb_reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    u_if.btn_raw = 5'd0;
    tick(1);
    pb_reset = 1'b0;
    tick(2);

    // Clean select press: exactly six edges, release gives no event
    n = cyc;
    u_if.btn_raw[2] = 1'b1;
    push_exp(n + 5, "s1_pre", 8'h00, 5'h00);
    push_exp(n + 6, "s1_press", 8'h04, 5'h04);
    tick(10);
    n = cyc;
    u_if.btn_raw[2] = 1'b0;
    push_exp(n + 6, "s1_rel", 8'h04, 5'h00);
    push_exp(n + 12, "s1_norel", 8'h04, 5'h00);
    tick(14);

    // Read on a foreign port, then on the event port
    n = cyc;
    push_exp(n + 3, "s3_wrongport", 8'h04, 5'h00);
    push_exp(n + 4, "s3_wrongport2", 8'h04, 5'h00);
    read_at(n + 3, 8'h0B);
    n = cyc;
    push_exp(n + 3, "s3_clear", 8'h00, 5'h00);
    read_at(n + 3, PORT);
    tick(2);

    // Glitch rejection, then a six-cycle pulse that is accepted
    n = cyc;
    u_if.btn_raw[3] = 1'b1;
    tick(3);
    u_if.btn_raw[3] = 1'b0;
    push_exp(n + 6, "s2_glitch", 8'h00, 5'h00);
    push_exp(n + 10, "s2_glitch2", 8'h00, 5'h00);
    tick(10);
    n = cyc;
    u_if.btn_raw[3] = 1'b1;
    push_exp(n + 5, "s2_pre", 8'h00, 5'h00);
    push_exp(n + 6, "s2_accept", 8'h08, 5'h08);
    tick(6);
    u_if.btn_raw[3] = 1'b0;
    tick(10);
    n = cyc;
    push_exp(n + 3, "s2_clear", 8'h00, 5'h00);
    read_at(n + 3, PORT);

    // Clear race with a scroll_up press, followed by auto-repeat
    n = cyc;
    u_if.btn_raw[2] = 1'b1;
    push_exp(n + 6, "s4_sel", 8'h04, 5'h04);
    tick(8);
    u_if.btn_raw[2] = 1'b0;
    tick(8);
    a = cyc + 6;
    u_if.btn_raw[0] = 1'b1;
    push_exp(a - 1, "s4_snap", 8'h04, 5'h00);
    push_exp(a, "s4_race", 8'h01, 5'h01);
    push_exp(a + 10, "s5_clr0", 8'h00, 5'h01);
    push_exp(a + 19, "s5_pre20", 8'h00, 5'h01);
    push_exp(a + 20, "s5_rep20", 8'h01, 5'h01);
    push_exp(a + 24, "s5_clr1", 8'h00, 5'h01);
    push_exp(a + 27, "s5_pre28", 8'h00, 5'h01);
    push_exp(a + 28, "s5_rep28", 8'h01, 5'h01);
    push_exp(a + 35, "s5_pre36", 8'h01, 5'h01);
    push_exp(a + 36, "s5_ovf", 8'h21, 5'h01);
    push_exp(a + 40, "s5_clr_ovf", 8'h00, 5'h01);
    push_exp(a + 44, "s5_rep44", 8'h01, 5'h01);
    push_exp(a + 48, "s5_clr3", 8'h00, 5'h01);
    push_exp(a + 51, "s5_pre52", 8'h00, 5'h01);
    push_exp(a + 52, "s5_rep52", 8'h01, 5'h01);
    push_exp(a + 59, "s5_rel", 8'h01, 5'h00);
    push_exp(a + 70, "s5_stop", 8'h01, 5'h00);
    read_at(a, PORT);
    read_at(a + 10, PORT);
    read_at(a + 24, PORT);
    read_at(a + 40, PORT);
    read_at(a + 48, PORT);
    wait_until(a + 53);
    u_if.btn_raw[0] = 1'b0;
    wait_until(a + 71);
    n = cyc;
    push_exp(n + 3, "s5_final_clr", 8'h00, 5'h00);
    read_at(n + 3, PORT);

    // Holding select never auto-repeats
    q = cyc;
    u_if.btn_raw[2] = 1'b1;
    push_exp(q + 6, "s5_sel", 8'h04, 5'h04);
    push_exp(q + 10, "s5_sel_clr", 8'h00, 5'h04);
    push_exp(q + 30, "s5_sel_norep", 8'h00, 5'h04);
    push_exp(q + 45, "s5_sel_norep2", 8'h00, 5'h04);
    read_at(q + 10, PORT);
    wait_until(q + 46);
    u_if.btn_raw[2] = 1'b0;
    tick(8);

    // Reset while scroll_down is repeating; button stays held through reset
    r = cyc;
    u_if.btn_raw[1] = 1'b1;
    push_exp(r + 6, "s6_press", 8'h02, 5'h02);
    push_exp(r + 10, "s6_clr", 8'h00, 5'h02);
    push_exp(r + 26, "s6_rep", 8'h02, 5'h02);
    read_at(r + 10, PORT);
    wait_until(r + 30);
    #2;
    pb_reset = 1'b1;
    #1;
    check_all_zero("s6_async_rst");
    tick(1);
    pb_reset = 1'b0;
    r = cyc;
    push_exp(r + 5, "s6_pre", 8'h00, 5'h00);
    push_exp(r + 6, "s6_press2", 8'h02, 5'h02);
    push_exp(r + 15, "s6_single", 8'h02, 5'h02);
    push_exp(r + 18, "s6_clr2", 8'h00, 5'h02);
    push_exp(r + 30, "s6_idle", 8'h00, 5'h00);
    read_at(r + 18, PORT);
    wait_until(r + 19);
    u_if.btn_raw[1] = 1'b0;
    wait_until(r + 31);

    tick(3);
    check_eq("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
